// File: rtl/cpu_multicycle.sv
// cpu_multicycle: FSM-sequenced DATA_W-bit core; 2 cycles per ALU/branch op, >=4 per memory op (stalls in MEM_WAIT while BUSYWAIT=1).
// Build with CPU_MULT_EN defined to add the iterative shift-add MULT (opcode 0x08, DATA_W+2 cycles); otherwise 0x08 is illegal.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  output logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              BUSYWAIT,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  output logic              READ,
  output logic              WRITE,
  output logic              ILLEGAL
);
  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
`ifdef CPU_MULT_EN
  localparam logic [2:0] S_MUL      = 3'd4;
  localparam logic [7:0] OP_MULT    = 8'h08;
`endif

  localparam logic [7:0] OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03,
                         OP_AND   = 8'h04, OP_OR  = 8'h05, OP_J   = 8'h06, OP_BEQ = 8'h07,
                         OP_SLL   = 8'h09, OP_SRL = 8'h0A, OP_SRA = 8'h0B, OP_ROR = 8'h0C,
                         OP_BNE   = 8'h0D, OP_LWD = 8'h0E, OP_LWI = 8'h0F, OP_SWD = 8'h10,
                         OP_SWI   = 8'h11;

  logic [2:0]                   state;
  logic [31:0]                  ir;
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [7:0]                   op, imm2;
  logic [RI_W-1:0]              rd_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0]            rt_val, rs_val, imm2_ext;
  logic signed [DATA_W-1:0]     sra_val;
  logic [31:0]                  sh_amt, rot_amt;
  logic [PC_W-1:0]              br_off, pc_plus4, pc_branch, pc_new;
  logic [DATA_W-1:0]            alu_res, mem_addr;
  logic                         alu_wr, mem_rd, mem_wr, illegal;
  logic                         unused_ok;

  assign op        = ir[31:24];
  assign imm2      = ir[7:0];
  assign rd_idx    = ir[16 +: RI_W];
  assign rt_idx    = ir[8 +: RI_W];
  assign rs_idx    = ir[0 +: RI_W];
  assign rt_val    = regs[rt_idx];
  assign rs_val    = regs[rs_idx];
  assign imm2_ext  = DATA_W'(imm2);
  assign sh_amt    = 32'(imm2);
  assign rot_amt   = sh_amt % DATA_W;
  // Arithmetic shift saturates to all sign bits on its own for large amounts.
  assign sra_val   = $signed(rt_val) >>> imm2;
  assign br_off    = PC_W'($signed(ir[23:16]));
  assign pc_plus4  = PC + PC_W'(4);
  assign pc_branch = pc_plus4 + (br_off << 2);
  assign unused_ok = ^ir[15:8];

`ifdef CPU_MULT_EN
  localparam int MC_W = $clog2(DATA_W) + 1;
  localparam logic [MC_W-1:0] MUL_LAST = MC_W'(DATA_W - 1);
  logic [DATA_W-1:0] mul_acc, mul_cand, mul_plier, mul_sum;
  logic [MC_W-1:0]   mul_cnt;
  logic              is_mul;
  assign mul_sum = mul_acc + (mul_plier[0] ? mul_cand : '0);
`endif

  always_comb begin
    alu_res  = '0;
    alu_wr   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = rs_val;
    illegal  = 1'b0;
    pc_new   = pc_plus4;
`ifdef CPU_MULT_EN
    is_mul   = 1'b0;
`endif
    case (op)
      OP_LOADI: begin alu_res = imm2_ext;        alu_wr = 1'b1; end
      OP_MOV:   begin alu_res = rs_val;          alu_wr = 1'b1; end
      OP_ADD:   begin alu_res = rt_val + rs_val; alu_wr = 1'b1; end
      OP_SUB:   begin alu_res = rt_val - rs_val; alu_wr = 1'b1; end
      OP_AND:   begin alu_res = rt_val & rs_val; alu_wr = 1'b1; end
      OP_OR:    begin alu_res = rt_val | rs_val; alu_wr = 1'b1; end
      OP_J:     pc_new = pc_branch;
      OP_BEQ:   if (rt_val == rs_val) pc_new = pc_branch;
      OP_BNE:   if (rt_val != rs_val) pc_new = pc_branch;
      OP_SLL: begin
        alu_wr = 1'b1;
        if (sh_amt < DATA_W) alu_res = rt_val << imm2;
      end
      OP_SRL: begin
        alu_wr = 1'b1;
        if (sh_amt < DATA_W) alu_res = rt_val >> imm2;
      end
      OP_SRA:   begin alu_res = sra_val; alu_wr = 1'b1; end
      OP_ROR: begin
        alu_wr  = 1'b1;
        alu_res = (rt_val >> rot_amt) | (rt_val << (DATA_W - rot_amt));
      end
      OP_LWD:   mem_rd = 1'b1;
      OP_LWI:   begin mem_rd = 1'b1; mem_addr = imm2_ext; end
      OP_SWD:   mem_wr = 1'b1;
      OP_SWI:   begin mem_wr = 1'b1; mem_addr = imm2_ext; end
`ifdef CPU_MULT_EN
      OP_MULT:  is_mul = 1'b1;
`endif
      default:  illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_FETCH;
      ir        <= '0;
      regs      <= '0;
      PC        <= '0;
      ADDRESS   <= '0;
      WRITEDATA <= '0;
      READ      <= 1'b0;
      WRITE     <= 1'b0;
      ILLEGAL   <= 1'b0;
`ifdef CPU_MULT_EN
      mul_acc   <= '0;
      mul_cand  <= '0;
      mul_plier <= '0;
      mul_cnt   <= '0;
`endif
    end else begin
      ILLEGAL <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= INSTRUCTION;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (mem_rd || mem_wr) begin
            ADDRESS   <= mem_addr;
            WRITEDATA <= rt_val;
            READ      <= mem_rd;
            WRITE     <= mem_wr;
            state     <= S_MEM_REQ;
          end
`ifdef CPU_MULT_EN
          else if (is_mul) begin
            mul_acc   <= '0;
            mul_cand  <= rt_val;
            mul_plier <= rs_val;
            mul_cnt   <= '0;
            state     <= S_MUL;
          end
`endif
          else begin
            if (alu_wr) regs[rd_idx] <= alu_res;
            ILLEGAL <= illegal;
            PC      <= pc_new;
            state   <= S_FETCH;
          end
        end
        // The memory sees the strobe for at least one cycle before BUSYWAIT is honoured.
        S_MEM_REQ: state <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (!BUSYWAIT) begin
            if (READ) regs[rd_idx] <= READDATA;
            READ  <= 1'b0;
            WRITE <= 1'b0;
            PC    <= pc_plus4;
            state <= S_FETCH;
          end
        end
`ifdef CPU_MULT_EN
        S_MUL: begin
          if (mul_cnt == MUL_LAST) begin
            regs[rd_idx] <= mul_sum;
            PC           <= pc_plus4;
            state        <= S_FETCH;
          end else begin
            mul_acc   <= mul_sum;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + 1'b1;
          end
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: register contents are observed through store instructions,
// with expected stores queued at stimulus time and checked as each WRITE strobe rises.
module tb_cpu_multicycle;
  localparam logic [31:0] LOOP = 32'h06FF_0000;  // J -1: park the core in place

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic        READ;
  logic        WRITE;
  logic        ILLEGAL;

  cpu_multicycle #(.DATA_W(8), .NREGS(8), .PC_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READ(READ), .WRITE(WRITE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } store_t;
  store_t      exp_q[$];
  string       tag_q[$];
  logic [31:0] imem [64];
  logic [7:0]  dmem [256];
  int          errors = 0;
  int          checks = 0;
  int          stall_n = 0;
  int          scnt = 0;
  int          read_hi = 0;
  int          write_hi = 0;
  int          ill_hi = 0;
  logic        prev_wr = 1'b0;

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_store(input string tag, input logic [7:0] a, input logic [7:0] d);
    store_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One clock: sample outputs at the falling edge, then play instruction and data memory.
  task automatic tick();
    store_t e;
    string  t;
    @(negedge CLK);
    if (READ)    read_hi++;
    if (WRITE)   write_hi++;
    if (ILLEGAL) ill_hi++;
    if (WRITE && !prev_wr) begin
      chk("store_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_addr"}, 32'(ADDRESS), 32'(e.addr));
        chk({t, "_data"}, 32'(WRITEDATA), 32'(e.data));
        dmem[ADDRESS] = WRITEDATA;
      end
    end
    prev_wr = WRITE;
    if (READ || WRITE) begin
      BUSYWAIT = (scnt < stall_n);
      scnt++;
    end else begin
      BUSYWAIT = 1'b0;
      scnt     = 0;
    end
    READDATA    = BUSYWAIT ? 8'h00 : dmem[ADDRESS];
    INSTRUCTION = imem[PC[7:2]];
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = LOOP;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    run(2);
    read_hi  = 0;
    write_hi = 0;
    ill_hi   = 0;
    stall_n  = 0;
    RESET    = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tag_q.delete();
  endtask

  initial begin
    RESET = 1'b0; INSTRUCTION = '0; READDATA = '0; BUSYWAIT = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    clear_prog();
    #1 RESET = 1'b1;
    #1;
    chk("rst_pc", PC, 32'd0);
    chk("rst_read", 32'(READ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_illegal", 32'(ILLEGAL), 32'd0);
    chk("rst_address", 32'(ADDRESS), 32'd0);
    chk("rst_writedata", 32'(WRITEDATA), 32'd0);

    // ALU: LOADI/SUB/ADD with wrap-around, 2 cycles per instruction
    clear_prog();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h05);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'h03);
    imem[2] = ins(8'h03, 8'h03, 8'h01, 8'h02);
    imem[3] = ins(8'h02, 8'h04, 8'h02, 8'h02);
    imem[4] = ins(8'h03, 8'h05, 8'h02, 8'h01);
    imem[5] = ins(8'h11, 8'h00, 8'h03, 8'h30);
    imem[6] = ins(8'h11, 8'h00, 8'h04, 8'h31);
    imem[7] = ins(8'h11, 8'h00, 8'h05, 8'h32);
    do_reset();
    expect_store("alu_sub", 8'h30, 8'h02);
    expect_store("alu_add", 8'h31, 8'h06);
    expect_store("alu_sub_wrap", 8'h32, 8'hFE);
    run(1);  chk("alu_pc_c1", PC, 32'd0);
    run(1);  chk("alu_pc_c2", PC, 32'd4);
    run(8);  chk("alu_pc_c10", PC, 32'd20);
    drain("alu", 40);

    // Branches at PC=8
    clear_prog();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h07);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'h01);
    imem[2] = ins(8'h07, 8'h02, 8'h01, 8'h01);
    imem[3] = ins(8'h11, 8'h00, 8'h02, 8'h41);
    imem[5] = ins(8'h11, 8'h00, 8'h01, 8'h40);
    do_reset();
    expect_store("beq_target", 8'h40, 8'h07);
    run(6);  chk("beq_pc", PC, 32'd20);
    drain("beq", 20);

    imem[2] = ins(8'h0D, 8'h02, 8'h01, 8'h01);
    imem[4] = LOOP;
    do_reset();
    expect_store("bne_fallthru", 8'h41, 8'h01);
    run(6);  chk("bne_pc", PC, 32'd12);
    drain("bne", 20);

    imem[2] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    do_reset();
    run(6);  chk("j_back_pc", PC, 32'd8);
    run(4);  chk("j_back_pc_again", PC, 32'd8);

    // Memory: stalled LWI, then unstalled SWD of the loaded value
    clear_prog();
    imem[0] = ins(8'h0F, 8'h06, 8'h00, 8'h10);
    imem[1] = ins(8'h10, 8'h00, 8'h06, 8'h07);
    dmem[8'h10] = 8'hA5;
    do_reset();
    stall_n = 5;
    expect_store("swd_loaded", 8'h00, 8'hA5);
    run(7);
    chk("lwi_read_held", 32'(READ), 32'd1);
    chk("lwi_pc_held", PC, 32'd0);
    chk("lwi_address", 32'(ADDRESS), 32'h10);
    stall_n = 0;
    run(1);
    chk("lwi_read_drop", 32'(READ), 32'd0);
    chk("lwi_read_len", 32'(read_hi), 32'd6);
    chk("lwi_pc_release", PC, 32'd4);
    run(4);
    chk("swd_write_len", 32'(write_hi), 32'd2);
    chk("swd_write_drop", 32'(WRITE), 32'd0);
    chk("swd_pc", PC, 32'd8);
    drain("mem", 10);

    // Shifts on 0x81, including out-of-range amounts
    clear_prog();
    imem[0]  = ins(8'h00, 8'h01, 8'h00, 8'h81);
    imem[1]  = ins(8'h09, 8'h02, 8'h01, 8'h01);
    imem[2]  = ins(8'h0A, 8'h03, 8'h01, 8'h01);
    imem[3]  = ins(8'h0B, 8'h04, 8'h01, 8'h01);
    imem[4]  = ins(8'h0C, 8'h05, 8'h01, 8'h09);
    imem[5]  = ins(8'h0B, 8'h06, 8'h01, 8'h0C);
    imem[6]  = ins(8'h0A, 8'h01, 8'h01, 8'h08);
    for (int i = 0; i < 5; i++) imem[7+i] = ins(8'h11, 8'h00, 8'(i + 2), 8'(8'h60 + i));
    imem[12] = ins(8'h11, 8'h00, 8'h01, 8'h65);
    do_reset();
    expect_store("sll1", 8'h60, 8'h02);
    expect_store("srl1", 8'h61, 8'h40);
    expect_store("sra1", 8'h62, 8'hC0);
    expect_store("ror9", 8'h63, 8'hC0);
    expect_store("sra12", 8'h64, 8'hFF);
    expect_store("srl8", 8'h65, 8'h00);
    drain("shift", 80);

    // Undefined opcode: one-cycle pulse, rd untouched, PC+4
    clear_prog();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h22);
    imem[1] = ins(8'h3F, 8'h01, 8'h01, 8'h01);
    imem[2] = ins(8'h11, 8'h00, 8'h01, 8'h70);
    do_reset();
    expect_store("ill_rd_kept", 8'h70, 8'h22);
    run(3);  chk("ill_low_before", 32'(ILLEGAL), 32'd0);
    run(1);  chk("ill_high", 32'(ILLEGAL), 32'd1);
    chk("ill_pc", PC, 32'd8);
    run(1);  chk("ill_low_after", 32'(ILLEGAL), 32'd0);
    drain("ill", 20);
    chk("ill_len", 32'(ill_hi), 32'd1);

    // MULT 13*21
    clear_prog();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h0D);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'h15);
    imem[2] = ins(8'h00, 8'h03, 8'h00, 8'h5A);
    imem[3] = ins(8'h08, 8'h03, 8'h01, 8'h02);
    imem[4] = ins(8'h11, 8'h00, 8'h03, 8'h80);
    do_reset();
`ifdef CPU_MULT_EN
    expect_store("mult_res", 8'h80, 8'h11);
    run(15); chk("mult_pc_busy", PC, 32'd12);
    run(1);  chk("mult_pc_done", PC, 32'd16);
    drain("mult", 20);
    chk("mult_no_illegal", 32'(ill_hi), 32'd0);
`else
    expect_store("mult_rd_kept", 8'h80, 8'h5A);
    run(8);
    chk("mult_illegal", 32'(ILLEGAL), 32'd1);
    chk("mult_pc", PC, 32'd16);
    drain("mult", 20);
    chk("mult_ill_len", 32'(ill_hi), 32'd1);
`endif

    // Reset asserted mid-MEM_WAIT
    clear_prog();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h33);
    imem[1] = ins(8'h0F, 8'h02, 8'h00, 8'h10);
    do_reset();
    stall_n = 20;
    run(7);
    chk("rr_read_before", 32'(READ), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rr_read_now", 32'(READ), 32'd0);
    chk("rr_pc_now", PC, 32'd0);
    clear_prog();
    imem[0] = ins(8'h11, 8'h00, 8'h01, 8'h90);
    imem[1] = ins(8'h11, 8'h00, 8'h02, 8'h91);
    stall_n = 0;
    run(3);
    chk("rr_pc_held", PC, 32'd0);
    chk("rr_write_held", 32'(WRITE), 32'd0);
    RESET = 1'b0;
    expect_store("rr_r1_zero", 8'h90, 8'h00);
    expect_store("rr_r2_zero", 8'h91, 8'h00);
    run(1);  chk("rr_no_write_c1", 32'(WRITE), 32'd0);
    run(1);  chk("rr_write_c2", 32'(WRITE), 32'd1);
    drain("rr", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
